// File: rtl/tbus_arbiter_pkg.sv
// tbus arbiter shared types and encodings.
// Op-type codes and arbiter FSM state.
package tbus_arbiter_pkg;

  localparam int TBUS_OPTYPE_W = 2;

  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_READ  = 2'd0;
  localparam logic [TBUS_OPTYPE_W-1:0] TBUS_WRITE = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_BUSY_LSU = 2'd1,
    ST_BUSY_IFU = 2'd2,
    ST_DRAIN    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/tbus_rr_pick.sv
// Two-request round-robin picker.
// prio=0 favours LSU on a tie, prio=1 favours IFU.
module tbus_rr_pick (
  input  logic req_lsu,
  input  logic req_ifu,
  input  logic prio,
  output logic gnt_lsu,
  output logic gnt_ifu
);

  // tie broken by prio, lone requester always wins
  always_comb begin
    gnt_lsu = req_lsu & (~req_ifu | ~prio);
    gnt_ifu = req_ifu & (~req_lsu | prio);
  end

endmodule

// File: rtl/tbus_arbiter.sv
// LSU/IFU to dcache tbus arbiter.
// Grant is locked until the slave reports done.
module tbus_arbiter
  import tbus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64,
  parameter int OPTYPE_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                lsu2arb_tbus_index_valid,
  output logic                lsu2arb_tbus_index_ready,
  input  logic [ADDR_W-1:0]   lsu2arb_tbus_index,
  input  logic [DATA_W-1:0]   lsu2arb_tbus_write_data,
  input  logic [DATA_W-1:0]   lsu2arb_tbus_write_mask,
  input  logic [OPTYPE_W-1:0] lsu2arb_tbus_operation_type,
  output logic [DATA_W-1:0]   lsu2arb_tbus_read_data,
  output logic                lsu2arb_tbus_operation_done,
  input  logic                ifu2arb_tbus_index_valid,
  output logic                ifu2arb_tbus_index_ready,
  input  logic [ADDR_W-1:0]   ifu2arb_tbus_index,
  input  logic [OPTYPE_W-1:0] ifu2arb_tbus_operation_type,
  output logic [DATA_W-1:0]   ifu2arb_tbus_read_data,
  output logic                ifu2arb_tbus_operation_done,
  input  logic                memblock2dcache_flush,
  output logic                arb2dcache_tbus_index_valid,
  input  logic                arb2dcache_tbus_index_ready,
  output logic [ADDR_W-1:0]   arb2dcache_tbus_index,
  output logic [DATA_W-1:0]   arb2dcache_tbus_write_data,
  output logic [DATA_W-1:0]   arb2dcache_tbus_write_mask,
  output logic [OPTYPE_W-1:0] arb2dcache_tbus_operation_type,
  input  logic [DATA_W-1:0]   arb2dcache_tbus_read_data,
  input  logic                arb2dcache_tbus_operation_done
);

  arb_state_e state;
  logic       prio;
  logic       idle;
  logic       gnt_lsu;
  logic       gnt_ifu;
  logic       fire;

  assign idle = (state == ST_IDLE);

  tbus_rr_pick u_pick (
    .req_lsu (lsu2arb_tbus_index_valid & idle),
    .req_ifu (ifu2arb_tbus_index_valid & idle),
    .prio    (prio),
    .gnt_lsu (gnt_lsu),
    .gnt_ifu (gnt_ifu)
  );

  assign arb2dcache_tbus_index_valid = gnt_lsu | gnt_ifu;
  assign lsu2arb_tbus_index_ready = gnt_lsu & arb2dcache_tbus_index_ready;
  assign ifu2arb_tbus_index_ready = gnt_ifu & arb2dcache_tbus_index_ready;
  assign fire = arb2dcache_tbus_index_valid & arb2dcache_tbus_index_ready;

  // forward the winner's request; IFU never writes
  always_comb begin
    arb2dcache_tbus_index          = '0;
    arb2dcache_tbus_write_data     = '0;
    arb2dcache_tbus_write_mask     = '0;
    arb2dcache_tbus_operation_type = '0;
    if (gnt_lsu) begin
      arb2dcache_tbus_index          = lsu2arb_tbus_index;
      arb2dcache_tbus_write_data     = lsu2arb_tbus_write_data;
      arb2dcache_tbus_write_mask     = lsu2arb_tbus_write_mask;
      arb2dcache_tbus_operation_type = lsu2arb_tbus_operation_type;
    end else if (gnt_ifu) begin
      arb2dcache_tbus_index          = ifu2arb_tbus_index;
      arb2dcache_tbus_operation_type = ifu2arb_tbus_operation_type;
    end
  end

  // route done only to the owner; DRAIN swallows it
  always_comb begin
    lsu2arb_tbus_operation_done =
      (state == ST_BUSY_LSU) & arb2dcache_tbus_operation_done;
    ifu2arb_tbus_operation_done =
      (state == ST_BUSY_IFU) & arb2dcache_tbus_operation_done;
    lsu2arb_tbus_read_data = lsu2arb_tbus_operation_done ?
      arb2dcache_tbus_read_data : '0;
    ifu2arb_tbus_read_data = ifu2arb_tbus_operation_done ?
      arb2dcache_tbus_read_data : '0;
  end

  // grant lock, flush drain and round-robin pointer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fire) begin
            prio <= gnt_lsu;
            if (gnt_lsu)
              state <= memblock2dcache_flush ? ST_DRAIN : ST_BUSY_LSU;
            else
              state <= ST_BUSY_IFU;
          end
        end
        ST_BUSY_LSU: begin
          if (arb2dcache_tbus_operation_done)
            state <= ST_IDLE;
          else if (memblock2dcache_flush)
            state <= ST_DRAIN;
        end
        ST_BUSY_IFU: begin
          if (arb2dcache_tbus_operation_done)
            state <= ST_IDLE;
        end
        ST_DRAIN: begin
          if (arb2dcache_tbus_operation_done)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
